serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor: the inverse-direction counterpart of the team's ripple full-adder cell. It computes a - b - bin using one full-subtractor cell and a borrow flip-flop, processing one bit per clock, LSB first.
- Used where area matters more than latency. Operands are loaded through a start/busy/done handshake, and the result is held until the next operation.

---
 rtl/serial_subtractor_if.sv | 30 +++
 rtl/serial_subtractor.sv | 111 +++++++++++
 tb/tb_serial_subtractor.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// ============================================================
// serial_subtractor_if : start/busy/done handshake bundle
// Rev 1.0
// ============================================================
`default_nettype none

interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================
// serial_subtractor : bit-serial a - b - bin, LSB first
// Rev 1.0
// ============================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_r_sr;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_br_next;
  logic             w_last;
  logic [WIDTH-1:0] w_r_next;

  // Full-subtractor cell on the current LSBs and the borrow flop
  assign w_ai      = r_a_sr[0];
  assign w_bi      = r_b_sr[0];
  assign w_d       = w_ai ^ w_bi ^ r_borrow;
  assign w_br_next = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_borrow);
  assign w_last    = (r_cnt == C_LAST);
  assign w_r_next  = (r_r_sr >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_SHIFT;
      S_SHIFT: if (w_last)    w_state_next = S_DONE;
      S_DONE:                 w_state_next = S_IDLE;
      default:                w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_r_sr   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_a_sr   <= bus.a;
            r_b_sr   <= bus.b;
            r_borrow <= bus.bin;
            r_cnt    <= '0;
          end
        end
        S_SHIFT: begin
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_r_sr   <= w_r_next;
          r_borrow <= w_br_next;
          r_cnt    <= r_cnt + 1'b1;
          // Result registers only move on the final bit; they hold otherwise
          if (w_last) begin
            r_diff <= w_r_next;
            r_bout <= w_br_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy = (r_state == S_SHIFT);
  assign bus.done = (r_state == S_DONE);
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================
// tb_serial_subtractor : directed bench for WIDTH=8 and WIDTH=1
// Rev 1.0
// ============================================================
`default_nettype none

module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cycle = 0;
  logic [7:0] last_diff = '0;
  logic       last_bout = 1'b0;

  serial_subtractor_if #(.WIDTH(8)) bus8 ();
  serial_subtractor_if #(.WIDTH(1)) bus1 ();

  serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_subtractor #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, want);
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input logic [7:0] ed, input logic eb, input bit mid_start);
    int cyc;
    int busy_cnt;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.bin = bin;
    @(negedge clk);
    bus8.start = 1'b0; bus8.a = ~a; bus8.b = 8'($urandom); bus8.bin = ~bin;
    cyc = 0; busy_cnt = 0;
    while (!bus8.done && cyc < 40) begin
      if (bus8.busy) busy_cnt++;
      if (cyc == 3) begin
        check("hold_diff", bus8.diff, last_diff);
        if (mid_start) begin
          bus8.start = 1'b1; bus8.a = 8'd1; bus8.b = 8'd2;
        end
      end
      if (cyc == 4) bus8.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    bus8.start = 1'b0;
    check("done_seen", bus8.done, 1);
    check("done_lat", cyc, 8);
    check("busy_cnt", busy_cnt, 8);
    check("diff", bus8.diff, ed);
    check("bout", bus8.bout, eb);
    @(negedge clk);
    check("done_pulse", bus8.done, 0);
    check("busy_after", bus8.busy, 0);
    last_diff = ed;
    last_bout = eb;
  endtask

  task automatic run1(input logic a, input logic b, input logic bin,
                      input logic ed, input logic eb);
    int cyc;
    @(negedge clk);
    bus1.start = 1'b1; bus1.a = a; bus1.b = b; bus1.bin = bin;
    @(negedge clk);
    bus1.start = 1'b0;
    check("w1_busy", bus1.busy, 1);
    cyc = 0;
    while (!bus1.done && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("w1_lat", cyc, 1);
    check("w1_diff", bus1.diff, ed);
    check("w1_bout", bus1.bout, eb);
  endtask

  task automatic wait_done8(output int at);
    int cyc;
    cyc = 0;
    while (!bus8.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("done_wait", bus8.done, 1);
    at = cycle;
  endtask

  task automatic wait_busy8(output int at);
    int cyc;
    cyc = 0;
    while (!bus8.busy && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_wait", bus8.busy, 1);
    at = cycle;
  endtask

  initial begin
    int t1, t2, tdone;
    bit saw_done;
    logic [7:0] ra, rb;
    logic rbin;
    logic [8:0] ref9;

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
    bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.bin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus8.busy, 0);
    check("rst_done", bus8.done, 0);
    check("rst_diff", bus8.diff, 0);
    check("rst_bout", bus8.bout, 0);
    check("rst_w1_diff", bus1.diff, 0);
    rst_n = 1'b1;

    run8(8'd100, 8'd37,  1'b0, 8'd63,  1'b0, 1'b0);
    run8(8'd0,   8'd1,   1'b0, 8'd255, 1'b1, 1'b0);
    run8(8'd0,   8'd255, 1'b1, 8'd0,   1'b1, 1'b0);
    run8(8'd200, 8'd200, 1'b0, 8'd0,   1'b0, 1'b0);
    run8(8'd5,   8'd5,   1'b1, 8'd255, 1'b1, 1'b0);
    run8(8'd255, 8'd0,   1'b1, 8'd254, 1'b0, 1'b0);
    run8(8'd50,  8'd20,  1'b0, 8'd30,  1'b0, 1'b1);

    // Reset mid-operation discards the operation
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'd9; bus8.b = 8'd4; bus8.bin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", bus8.busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mrst_busy", bus8.busy, 0);
    check("mrst_done", bus8.done, 0);
    check("mrst_diff", bus8.diff, 0);
    check("mrst_bout", bus8.bout, 0);
    saw_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done) saw_done = 1'b1;
    end
    check("mrst_no_done", saw_done, 0);
    last_diff = 8'd0;
    last_bout = 1'b0;
    run8(8'd9, 8'd4, 1'b0, 8'd5, 1'b0, 1'b0);

    // Back-to-back with start held high
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'd10; bus8.b = 8'd3; bus8.bin = 1'b0;
    @(negedge clk);
    t1 = cycle;
    check("b2b_busy1", bus8.busy, 1);
    bus8.a = 8'd3; bus8.b = 8'd10;
    wait_done8(tdone);
    check("b2b_diff1", bus8.diff, 7);
    check("b2b_bout1", bus8.bout, 0);
    @(negedge clk);
    check("b2b_idle", bus8.busy, 0);
    wait_busy8(t2);
    check("b2b_period", t2 - t1, 10);
    check("b2b_hold", bus8.diff, 7);
    wait_done8(tdone);
    bus8.start = 1'b0;
    check("b2b_diff2", bus8.diff, 249);
    check("b2b_bout2", bus8.bout, 1);
    last_diff = 8'd249;
    last_bout = 1'b1;
    repeat (3) @(negedge clk);
    check("b2b_stop", bus8.busy, 0);

    // Random operands against the unsigned reference
    for (int i = 0; i < 60; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      ref9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
      run8(ra, rb, rbin, ref9[7:0], ref9[8], 1'b0);
    end

    // WIDTH=1: every input combination
    run1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run1(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    run1(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    run1(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    run1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
